counter_timer: RTL and testbench

- Parametrised successor to the team's free-running 8-bit blink counter.
- Adds a programmable prescaler, up/down counting, a programmable terminal limit, parallel load, four terminal-count modes, start/stop control, a compare/PWM output and a selectable blink tap.
- Serves as the general timer/counter peripheral core, used for LED blink, periodic tick generation and simple PWM in the processor test platform.

---
 rtl/counter_timer_pkg.sv | 8 +
 rtl/counter_timer_tick_prescaler.sv | 19 +
 rtl/counter_timer.sv | 74 +++++++
 tb/tb_counter_timer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/counter_timer_pkg.sv
// counter_timer_pkg: mode encodings and FSM state type shared by the timer core.
package counter_timer_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RELOAD  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/counter_timer_tick_prescaler.sv
// tick_prescaler: emits a tick every prescale+1 enabled cycles; count held at 0 while disabled.
module tick_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] prescale,
  output logic         tick
);
  localparam logic [W-1:0] ONE = 1;
  logic [W-1:0] pre_cnt_q, pre_cnt_d;
  assign tick = en && (pre_cnt_q == prescale);
  always_comb pre_cnt_d = (!en || clr || tick) ? '0 : pre_cnt_q + ONE;
  always_ff @(posedge clk)
    if (reset) pre_cnt_q <= '0;
    else pre_cnt_q <= pre_cnt_d;
endmodule

// File: rtl/counter_timer.sv
// counter_timer: prescaled up/down timer with terminal-count modes, PWM compare and blink tap.
module counter_timer
  import counter_timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  parameter int BLINK_BIT  = WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            mode,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      compare,
  output logic [WIDTH-1:0]      counter,
  output logic                  tc,
  output logic                  running,
  output logic                  done,
  output logic                  pwm,
  output logic                  blink
);
  localparam logic [WIDTH-1:0] ONE = 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic tc_q, tc_d, tick, ev, term;
  tick_prescaler #(.W(PRESCALE_W)) u_pre (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_RUN),
    .clr      (load | stop),
    .prescale (prescale),
    .tick     (tick)
  );
  // a tick is swallowed by a load or by a stop that pauses the timer this cycle
  always_comb begin
    ev = tick && !stop && !load;
    term = dir ? (counter_q == '0) : (counter_q == limit);
    tc_d = ev && term;
    counter_d = load ? load_value
              : (ev && !term) ? (dir ? counter_q - ONE : counter_q + ONE)
              : !ev ? counter_q
              : mode == MODE_WRAP ? (dir ? limit : '0)
              : mode == MODE_RELOAD ? load_value
              : counter_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = (start && !stop) ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = stop ? ST_IDLE : (tc_d && mode == MODE_ONESHOT) ? ST_DONE : ST_RUN;
      ST_DONE: state_d = (start && !stop) ? ST_RUN : load ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      tc_q      <= tc_d;
    end
  assign counter = counter_q;
  assign tc      = tc_q;
  assign running = state_q == ST_RUN;
  assign done    = state_q == ST_DONE;
  assign pwm     = counter_q < compare;
  assign blink   = counter_q[BLINK_BIT];
endmodule

// File: tb/tb_counter_timer.sv
// tb_counter_timer: directed plan checks plus randomized run against an arithmetic timer model.
module tb_counter_timer;
  logic clk = 0, reset = 1, start = 0, stop = 0, load = 0, dir = 0;
  logic [7:0] load_value = 0, limit = 0, prescale = 0, compare = 0;
  logic [1:0] mode = 0;
  logic [7:0] counter;
  logic tc, running, done, pwm, blink;
  int checks = 0, errors = 0;
  bit check_on = 0;
  int m_state = 0, m_cnt = 0, m_pre = 0;
  bit m_tc = 0;

  counter_timer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_value(load_value), .limit(limit), .prescale(prescale), .mode(mode),
    .dir(dir), .compare(compare), .counter(counter), .tc(tc), .running(running),
    .done(done), .pwm(pwm), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // model states: 0 idle, 1 run, 2 done; counts kept as plain integers mod 256
  always @(posedge clk) begin : model
    int nc, ns, np;
    bit tk, ev, term, nt;
    if (reset) begin
      m_state <= 0; m_cnt <= 0; m_pre <= 0; m_tc <= 0;
    end else begin
      tk = (m_state == 1) && (m_pre == int'(prescale));
      ev = tk && !stop && !load;
      term = dir ? (m_cnt == 0) : (m_cnt == int'(limit));
      nt = ev && term;
      nc = m_cnt;
      ns = m_state;
      if (load) nc = load_value;
      else if (ev && !term) nc = (m_cnt + (dir ? 255 : 1)) % 256;
      else if (ev)
        case (mode)
          2'd0: nc = dir ? int'(limit) : 0;
          2'd3: nc = load_value;
          default: nc = m_cnt;
        endcase
      if (m_state == 0 && start && !stop) ns = 1;
      else if (m_state == 1 && stop) ns = 0;
      else if (m_state == 1 && nt && mode == 2'd2) ns = 2;
      else if (m_state == 2) ns = (start && !stop) ? 1 : load ? 0 : 2;
      np = (m_state == 1 && !load && !stop && !tk) ? (m_pre + 1) % 256 : 0;
      m_state <= ns; m_cnt <= nc; m_pre <= np; m_tc <= nt;
    end
  end

  always @(negedge clk)
    if (check_on) begin
      chk("counter", counter, m_cnt);
      chk("tc", tc, m_tc);
      chk("running", running, m_state == 1);
      chk("done", done, m_state == 2);
      chk("pwm", pwm, m_cnt < int'(compare));
      chk("blink", blink, m_cnt >= 128);
    end

  initial begin
    compare = 5;
    repeat (3) cyc();
    chk("rst_counter", counter, 0);
    chk("rst_tc", tc, 0);
    chk("rst_running", running, 0);
    chk("rst_blink", blink, 0);
    chk("rst_pwm", pwm, 1);
    reset = 0;
    check_on = 1;
    // WRAP up, limit 3
    mode = 0; dir = 0; limit = 3; prescale = 0; start = 1;
    cyc(); start = 0;
    chk("wrap_c0", counter, 0); chk("wrap_run", running, 1);
    cyc(); chk("wrap_c1", counter, 1);
    cyc(); cyc(); chk("wrap_c3", counter, 3); chk("wrap_tc3", tc, 0);
    cyc(); chk("wrap_c0b", counter, 0); chk("wrap_tc", tc, 1); chk("wrap_run2", running, 1);
    cyc(); chk("wrap_tc_off", tc, 0);
    stop = 1; cyc(); stop = 0; chk("stop_idle", running, 0);
    // prescale 2 and PWM
    load_value = 0; limit = 5; compare = 3; prescale = 2; load = 1; start = 1;
    cyc(); load = 0; start = 0;
    cyc(); cyc(); chk("pre_hold", counter, 0); chk("pre_pwm0", pwm, 1);
    cyc(); chk("pre_c1", counter, 1);
    repeat (6) cyc(); chk("pre_c3", counter, 3); chk("pre_pwm3", pwm, 0);
    stop = 1; cyc(); stop = 0;
    // ONE_SHOT down from 2
    prescale = 0; mode = 2; dir = 1; load_value = 2; load = 1; start = 1;
    cyc(); load = 0; start = 0;
    chk("os_c2", counter, 2);
    cyc(); cyc(); chk("os_c0", counter, 0); chk("os_tc0", tc, 0);
    cyc(); chk("os_hold", counter, 0); chk("os_tc", tc, 1); chk("os_done", done, 1); chk("os_run", running, 0);
    cyc(); chk("os_tc_off", tc, 0); chk("os_done2", done, 1);
    start = 1; cyc(); start = 0; chk("os_restart", running, 1);
    // AUTO_RELOAD 6..8
    mode = 3; dir = 0; load_value = 6; limit = 8; load = 1;
    cyc(); load = 0; chk("ar_c6", counter, 6);
    cyc(); cyc(); chk("ar_c8", counter, 8);
    cyc(); chk("ar_reload", counter, 6); chk("ar_tc", tc, 1);
    cyc(); chk("ar_c7", counter, 7); chk("ar_tc_off", tc, 0);
    // SATURATE at 4
    mode = 1; limit = 4; load_value = 2; load = 1;
    cyc(); load = 0;
    cyc(); cyc(); chk("sat_c4", counter, 4); chk("sat_tc0", tc, 0);
    cyc(); chk("sat_hold", counter, 4); chk("sat_tc1", tc, 1);
    cyc(); chk("sat_tc2", tc, 1);
    stop = 1; cyc(); stop = 0;
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    chk("startstop", running, 0);
    // load wins over a terminal tick
    mode = 0; limit = 3; load_value = 3; load = 1; start = 1;
    cyc(); start = 0; load_value = 9;
    cyc(); load = 0; chk("ldterm_c", counter, 9); chk("ldterm_tc", tc, 0);
    // blink across 127/128 and 255 wrap
    limit = 255; load_value = 127; load = 1;
    cyc(); load = 0; chk("bl_127", blink, 0);
    cyc(); chk("bl_128c", counter, 128); chk("bl_128", blink, 1);
    load_value = 255; load = 1; cyc(); load = 0;
    cyc(); chk("w255_c", counter, 0); chk("w255_tc", tc, 1); chk("w255_bl", blink, 0);
    reset = 1; cyc(); reset = 0;
    chk("midrst_c", counter, 0); chk("midrst_run", running, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 500) == 0;
      start = ($urandom % 8) == 0;
      stop = ($urandom % 16) == 0;
      load = ($urandom % 12) == 0;
      load_value = ($urandom % 3 == 0) ? 8'($urandom) : 8'($urandom % 12);
      if ($urandom % 20 == 0) limit = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 12);
      if ($urandom % 20 == 0) mode = 2'($urandom);
      if ($urandom % 20 == 0) dir = 1'($urandom);
      if ($urandom % 10 == 0) compare = 8'($urandom % 16);
      if ($urandom % 50 == 0) prescale = 8'($urandom % 4);
      cyc();
    end
    reset = 0; start = 0; stop = 0; load = 0;
    cyc();
    check_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
